// File: rtl/aes_pkg.sv
// Shared definitions for the AES inverse-cipher slice.
// Contents:
//   byte_t / column_t / state_t : byte, 4-byte column and 16-byte block types.
//                                 Element 15 of a state_t is FIPS byte 0.
//   NB, NR_AES128/192/256       : block width in words and round counts.
//   xtime, gf_mul               : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1.
//   inv_mix_column              : InvMixColumns applied to one column.
package aes_pkg;

    typedef logic [7:0]       byte_t;
    typedef logic [3:0][7:0]  column_t;
    typedef logic [15:0][7:0] state_t;

    localparam int NB        = 4;
    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Column element 3 is row 0, element 0 is row 3 (same descending order
    // as the block itself).
    function automatic column_t inv_mix_column(input column_t col);
        byte_t a0, a1, a2, a3;
        column_t res;
        a0 = col[3];
        a1 = col[2];
        a2 = col[1];
        a3 = col[0];
        res[3] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        res[2] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        res[1] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        res[0] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        return res;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_core_sbox.sv
// Combinational AES inverse S-box (256-entry lookup).
// Ports:
//   in_byte  : byte to substitute
//   out_byte : InvSubBytes(in_byte)
module aes_inv_sbox
    import aes_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);

    // Entry 0 sits in the most significant byte of the first row literal.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES inverse cipher: one decryption round per clock.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : ciphertext handshake; in_state is the block
//   rk_idx / rk_in       : round-key lookup into an external expanded key
//                          store, answered combinationally in the same cycle
//   out_valid / out_ready: plaintext handshake; out_state is the block
// Blocks use element 15 = FIPS byte 0 ordering throughout.
module aes_inv_cipher_core
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = NR_AES128
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  state_t in_state,
    output logic [3:0] rk_idx,
    input  state_t rk_in,
    output logic   out_valid,
    input  logic   out_ready,
    output state_t out_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0] fsm;
    logic [3:0] counter;
    state_t     state_reg;

    state_t shifted;
    state_t subbed;
    state_t added;
    state_t mixed;

    // InvShiftRows: FIPS byte (r,c) takes byte (r,(c-r) mod 4).
    for (genvar k = 0; k < 16; k++) begin : g_isr
        localparam int R   = k % 4;
        localparam int C   = k / 4;
        localparam int SRC = R + 4 * ((C - R + 4) % 4);
        assign shifted[15-k] = state_reg[15-SRC];
    end

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .in_byte  (shifted[i]),
            .out_byte (subbed[i])
        );
    end

    assign added = subbed ^ rk_in;

    // Column c occupies elements 15-4c down to 12-4c.
    for (genvar c = 0; c < 4; c++) begin : g_imix
        assign mixed[15-4*c -: 4] = inv_mix_column(added[15-4*c -: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= S_IDLE;
            counter   <= '0;
            state_reg <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_state ^ rk_in;
                        counter   <= 4'(NUM_ROUNDS - 1);
                        fsm       <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    // The final round (counter 0) skips InvMixColumns.
                    if (counter != 4'd0) begin
                        state_reg <= mixed;
                        counter   <= counter - 4'd1;
                    end else begin
                        state_reg <= added;
                        fsm       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) fsm <= S_IDLE;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

    // Key index depends only on registered state so the external store
    // never sees a path from the handshake inputs.
    always_comb begin
        rk_idx = 4'(NUM_ROUNDS);
        case (fsm)
            S_IDLE:  rk_idx = 4'(NUM_ROUNDS);
            S_ROUND: rk_idx = counter;
            S_DONE:  rk_idx = 4'd0;
            default: rk_idx = 4'(NUM_ROUNDS);
        endcase
    end

    assign in_ready  = (fsm == S_IDLE);
    assign out_valid = (fsm == S_DONE);
    // Intermediate round values are never exposed on the output bus.
    assign out_state = (fsm == S_DONE) ? state_reg : '0;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Self-checking bench for aes_inv_cipher_core (AES-128 configuration).
// The bench derives its own S-box algorithmically, expands keys and
// encrypts with a forward-cipher model; a small inverse model covers the
// all-zero key-store case.
module tb_aes_inv_cipher_core;
    import aes_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    state_t     in_state;
    logic [3:0] rk_idx;
    state_t     rk_in;
    logic       out_valid;
    logic       out_ready;
    state_t     out_state;

    state_t     ks [0:10];
    logic [7:0] sbox_t  [0:255];
    logic [7:0] isbox_t [0:255];

    int errors = 0;
    int checks = 0;

    aes_inv_cipher_core #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .rk_idx    (rk_idx),
        .rk_in     (rk_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    assign rk_in = (rk_idx <= 4'd10) ? ks[rk_idx] : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] bb;
        logic [7:0] p;
        aa = {1'b0, a};
        bb = b;
        p  = 8'h00;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic state_t subBytes(input state_t s, input bit inv);
        state_t o;
        for (int i = 0; i < 16; i++) o[i] = inv ? isbox_t[s[i]] : sbox_t[s[i]];
        return o;
    endfunction

    function automatic state_t shiftRows(input state_t s, input bit inv);
        state_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                int src;
                src = inv ? ((c - r) & 3) : ((c + r) & 3);
                o[15-(r+4*c)] = s[15-(r+4*src)];
            end
        return o;
    endfunction

    function automatic state_t mixCols(input state_t s, input bit inv);
        state_t o;
        logic [7:0] cf [0:3];
        logic [7:0] acc;
        if (inv) begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(cf[(j - r) & 3], s[15-(j+4*c)]);
                o[15-(r+4*c)] = acc;
            end
        return o;
    endfunction

    function automatic state_t encryptModel(input state_t pt);
        state_t s;
        s = pt ^ ks[0];
        for (int rd = 1; rd <= 10; rd++) begin
            s = subBytes(s, 1'b0);
            s = shiftRows(s, 1'b0);
            if (rd != 10) s = mixCols(s, 1'b0);
            s = s ^ ks[rd];
        end
        return s;
    endfunction

    function automatic state_t decryptModel(input state_t ct);
        state_t s;
        s = ct ^ ks[10];
        for (int rd = 9; rd >= 0; rd--) begin
            s = shiftRows(s, 1'b1);
            s = subBytes(s, 1'b1);
            s = s ^ ks[rd];
            if (rd != 0) s = mixCols(s, 1'b1);
        end
        return s;
    endfunction

    task automatic buildSbox();
        logic [7:0] y;
        logic [7:0] v;
        for (int x = 0; x < 256; x++) begin
            y = 8'h01;
            repeat (254) y = gmul(y, 8'(x));
            if (x == 0) y = 8'h00;
            v = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
            sbox_t[x]  = v;
            isbox_t[v] = 8'(x);
        end
    endtask

    task automatic expandKey(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic waitOutValid(input int limit, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic applyStimulus(input state_t blk);
        int n;
        @(negedge clk);
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_state = blk;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = '0;
    endtask

    task automatic runBlock(input state_t ct, input state_t exp, input string tag);
        int n;
        applyStimulus(ct);
        @(negedge clk);
        waitOutValid(20, n);
        checkOutput({tag, "_valid"}, 128'(out_valid), 128'(1));
        checkOutput(tag, out_state, exp);
    endtask

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2  = 128'hffeeddccbbaa99887766554433221100;

    initial begin
        state_t ct2;
        state_t got1;
        state_t zdec;
        state_t pt;
        int acc_n;
        int n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;
        buildSbox();
        expandKey(KEY1);
        checkOutput("model_fips_c1", encryptModel(PT1), CT1);
        ct2 = encryptModel(PT2);

        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready",  128'(in_ready),  128'(1));
        checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
        checkOutput("reset_out_state", out_state, 128'(0));
        checkOutput("reset_rk_idx",    128'(rk_idx),    128'(10));
        rst_n = 1'b1;

        // FIPS-197 C.1 with exact latency and rk_idx sequence
        @(negedge clk);
        checkOutput("idle_rk_idx", 128'(rk_idx), 128'(10));
        in_valid = 1'b1;
        in_state = CT1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("round_rk_idx_%0d", 9 - i), 128'(rk_idx), 128'(9 - i));
            checkOutput($sformatf("no_early_valid_%0d", i), 128'(out_valid), 128'(0));
        end
        @(negedge clk);
        checkOutput("c1_latency_valid", 128'(out_valid), 128'(1));
        checkOutput("c1_plaintext",     out_state, PT1);
        checkOutput("done_rk_idx",      128'(rk_idx), 128'(0));

        // Backpressure: hold for 5 cycles, a busy-time in_valid is ignored
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_state = ct2;
            @(negedge clk);
            checkOutput("bp_valid",    128'(out_valid), 128'(1));
            checkOutput("bp_stable",   out_state, PT1);
            checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
            checkOutput("bp_rk_idx",   128'(rk_idx), 128'(0));
        end
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_out_valid", 128'(out_valid), 128'(0));
        checkOutput("release_in_ready",  128'(in_ready),  128'(1));

        // Back-to-back with in_valid held high
        in_valid = 1'b1;
        in_state = CT1;
        @(posedge clk);
        #1;
        in_state = ct2;
        got1  = '0;
        acc_n = 0;
        n     = 0;
        while (acc_n == 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1) got1 = out_state;
            if (in_ready === 1'b1) acc_n = n;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = '0;
        checkOutput("b2b_accept_gap", 128'(acc_n), 128'(12));
        checkOutput("b2b_first",      got1, PT1);
        @(negedge clk);
        waitOutValid(20, n);
        checkOutput("b2b_second_valid", 128'(out_valid), 128'(1));
        checkOutput("b2b_second",       out_state, PT2);

        // Reset in the middle of a block
        applyStimulus(CT1);
        repeat (5) @(negedge clk);
        checkOutput("mid_no_valid", 128'(out_valid), 128'(0));
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 128'(out_valid), 128'(0));
        checkOutput("abort_in_ready",  128'(in_ready),  128'(1));
        checkOutput("abort_rk_idx",    128'(rk_idx),    128'(10));
        checkOutput("abort_out_state", out_state, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        runBlock(CT1, PT1, "after_reset");

        // All-zero key store, zero ciphertext
        for (int r = 0; r <= 10; r++) ks[r] = '0;
        zdec = decryptModel('0);
        checkOutput("zero_model_roundtrip", encryptModel(zdec), 128'(0));
        runBlock('0, zdec, "zero_key");

        // Random regression against the forward model
        for (int b = 0; b < 1000; b++) begin
            expandKey({$urandom, $urandom, $urandom, $urandom});
            pt = {$urandom, $urandom, $urandom, $urandom};
            runBlock(encryptModel(pt), pt, $sformatf("rand_%0d", b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
